mem_access_initiator: RTL and testbench
=======================================

Name: mem_access_initiator

Overview:
Initiator side of the MOV/MOC memory handshake. Takes one load/store request at a time from the CPU control unit and drives the byte-addressed RAM's MOV, ReadWrite, MS_2_0, Address and DataIn. Waits for MOC, captures DataOut, then clears MOC with MOCoff. Sits between the datapath MAR/MDR and the RAM, and checks alignment, illegal sizes and handshake timeouts.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_MOC or RELEASE before the access is aborted with err.
CHECK_ALIGN, 1, when 1, misaligned halfword/word requests are rejected; when 0, they are issued unchanged.

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req  in  1  access request, sampled only in IDLE
req_rw  in  1  1 = read, 0 = write (same encoding as ReadWrite)
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  sign-extend read data
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on rejected or aborted access
rdata  out  32  extended read data, valid from the done pulse until the next accepted read
MOV  out  1  memory operation valid
ReadWrite  out  1  to RAM
MS_2_0  out  3  {req_signed, req_size}
Address  out  32  to RAM
DataIn  out  32  store data to RAM
MOCoff  out  1  clears RAM MOC
MOC  in  1  RAM operation complete
DataOut  in  32  RAM read bus

Behaviour:
- Reset: FSM goes to IDLE and all outputs go to 0 (MOV, MOCoff, busy, done, err, rdata, ReadWrite, MS_2_0, Address, DataIn). Reset in mid-access abandons the access with no done or err pulse.
- All RAM-side outputs and all status outputs are registered. The request fields are latched into internal registers on acceptance.
- IDLE:
  - req=1 accepts the request.
  - req_size=11 goes to ERR.
  - With CHECK_ALIGN=1, a halfword with addr[0]=1 or a word with addr[1:0]≠00 goes to ERR.
  - Otherwise the next state is PRECLEAR if MOC=1 (stale completion), else ISSUE.
- PRECLEAR: MOCoff=1, MOV=0. Stay until MOC=0, then go to ISSUE. Bounded by the timeout counter; expiry goes to ERR.
- ISSUE: drive Address, DataIn, ReadWrite, MS_2_0 from the latched request. Set MOV=1, MOCoff=0. Clear the counter and go to WAIT_MOC.
- WAIT_MOC: hold MOV=1 and all RAM-side outputs stable.
  - MOC=1: if read, capture rdata, then go to RELEASE.
  - Counter reaches TIMEOUT_CYCLES-1 with MOC=0: go to ABORT.
- RELEASE: MOV=0, MOCoff=1. Stay until MOC=0, then go to DONE. Timeout goes to ABORT.
- DONE: done=1 for one cycle, MOCoff=0, then go to IDLE.
- ABORT: MOV=0, MOCoff=1, err=1 for one cycle, then go to IDLE. MOCoff drops in IDLE.
- ERR: err=1 for one cycle with no RAM activity (MOV never asserted), then go to IDLE.
- req while busy is ignored; the CPU must hold or re-issue it. A req in the DONE cycle is ignored; the earliest next accept is the following IDLE cycle.
- Read data formation from DataOut:
  - byte: bits [7:0], extended from bit 7.
  - halfword: bits [15:0], extended from bit 15.
  - word: all 32 bits.
  - Extension is sign when req_signed=1, zero otherwise. It does not depend on RAM-side extension.
- Writes: DataIn = req_wdata unmodified. The RAM stores the low byte(s), big-endian at Address.
- Latency with a zero-wait RAM (MOC rises while MOV=1 in the same cycle, falls when MOCoff=1):
  - accept at edge T0, MOV=1 during T1, RELEASE during T2, done during T3.
  - An access is 4 cycles IDLE-to-IDLE.
- Timeout counter: 8 bits, saturating, cleared on every state entry.

Decomposition:
- Package mem_if_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - the state enumeration IDLE, PRECLEAR, ISSUE, WAIT_MOC, RELEASE, DONE, ABORT, ERR.
  - RW_READ=1 and RW_WRITE=0.
- One combinational sub-module, mem_rdata_extend (DataOut, size, signed → rdata), shared with any future cache fill path.

Test Plan:
- Word write then word read: write addr 0x10 with wdata 0xDEADBEEF. Read 0x10 → rdata=0xDEADBEEF, done at T3, MOV high exactly one cycle per access with the zero-wait model.
- Signed/unsigned byte read: memory[0x21]=0x85. Signed → rdata=0xFFFFFF85; unsigned → rdata=0x00000085.
- Halfword signed read: memory[0x30..0x31]=0x80,0x01 → rdata=0xFFFF8001. Unsigned → 0x00008001.
- Misaligned word at 0x13 and size=11 → err pulse 1 cycle after accept, MOV never high, busy drops the next cycle.
- RAM model that never raises MOC → MOV held TIMEOUT_CYCLES cycles, then ABORT: err=1, MOCoff=1, no done. The next request completes normally.
- Stale MOC=1 at accept → PRECLEAR asserts MOCoff until MOC=0, then MOV issues. Reset asserted during WAIT_MOC → next cycle all outputs 0, no done/err.

Source files
------------

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared encodings for the MOV/MOC memory handshake.
// Size codes, read/write polarity and the initiator state set.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    PRECLEAR,
    ISSUE,
    WAIT_MOC,
    RELEASE,
    DONE,
    ABORT,
    ERR
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    return (sz == SZ_HALF && a[0]) ||
           (sz == SZ_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_rdata_extend.sv
// mem_rdata_extend: right-aligned RAM read data to a 32-bit value.
// Sign or zero extension is ours, independent of the RAM's own.
module mem_rdata_extend
  import mem_if_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] rdata
);

  // pick the live bytes and extend from their top bit
  always_comb begin
    rdata = dout;
    unique case (1'b1)
      size == SZ_BYTE:
        rdata = {{24{sgn & dout[7]}}, dout[7:0]};
      size == SZ_HALF:
        rdata = {{16{sgn & dout[15]}}, dout[15:0]};
      default:
        rdata = dout;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// mem_access_initiator: one load/store at a time over MOV/MOC.
// Checks size/alignment, clears stale MOC, times out dead RAM.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [2:0]  MS_2_0,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  output logic        MOCoff,
  input  logic        MOC,
  input  logic [31:0] DataOut
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      nxt;
  state_t      state_d;
  logic [7:0]  cnt;
  logic        tmo;
  logic        accept;
  logic        issue;
  logic        from_idle;

  logic        lat_rw;
  logic [1:0]  lat_size;
  logic        lat_sgn;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        src_rw;
  logic [1:0]  src_size;
  logic        src_sgn;
  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic [31:0] ext_data;

  assign tmo = cnt >= TMO_LAST;

  mem_rdata_extend u_ext (
    .dout  (DataOut),
    .size  (lat_size),
    .sgn   (lat_sgn),
    .rdata (ext_data)
  );

  // next state; ISSUE resolves on the edge into WAIT_MOC so MOV
  // is already up in the cycle right after accept
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (req_size == SZ_BAD)
            nxt = ERR;
          else if (CHECK_ALIGN &&
                   misaligned(req_size, req_addr[1:0]))
            nxt = ERR;
          else if (MOC)
            nxt = PRECLEAR;
          else
            nxt = ISSUE;
        end
      end
      PRECLEAR: begin
        if (!MOC)     nxt = ISSUE;
        else if (tmo) nxt = ERR;
      end
      ISSUE:    nxt = WAIT_MOC;
      WAIT_MOC: begin
        if (MOC)      nxt = RELEASE;
        else if (tmo) nxt = ABORT;
      end
      RELEASE: begin
        if (!MOC)     nxt = DONE;
        else if (tmo) nxt = ABORT;
      end
      DONE:     nxt = IDLE;
      ABORT:    nxt = IDLE;
      ERR:      nxt = IDLE;
    endcase
    issue   = (nxt == ISSUE);
    state_d = issue ? WAIT_MOC : nxt;
  end

  // request source for the RAM bus: live fields when issuing
  // straight from IDLE, latched copy when coming out of PRECLEAR
  always_comb begin
    from_idle = (state == IDLE);
    src_rw    = from_idle ? req_rw     : lat_rw;
    src_size  = from_idle ? req_size   : lat_size;
    src_sgn   = from_idle ? req_signed : lat_sgn;
    src_addr  = from_idle ? req_addr   : lat_addr;
    src_wdata = from_idle ? req_wdata  : lat_wdata;
  end

  // state register and per-state saturating timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      if (state_d != state)
        cnt <= 8'd0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  // hold the accepted request for the life of the access
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_rw    <= RW_WRITE;
      lat_size  <= SZ_BYTE;
      lat_sgn   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_rw    <= req_rw;
      lat_size  <= req_size;
      lat_sgn   <= req_signed;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // registered handshake/status outputs decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      MOV    <= 1'b0;
      MOCoff <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      MOV    <= state_d == WAIT_MOC;
      MOCoff <= state_d == PRECLEAR ||
                state_d == RELEASE  ||
                state_d == ABORT;
      busy   <= state_d != IDLE;
      done   <= state_d == DONE;
      err    <= state_d == ABORT || state_d == ERR;
    end
  end

  // RAM bus loads on issue and stays put until the next issue
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadWrite <= 1'b0;
      MS_2_0    <= 3'b000;
      Address   <= '0;
      DataIn    <= '0;
    end else if (issue) begin
      ReadWrite <= src_rw;
      MS_2_0    <= {src_sgn, src_size};
      Address   <= src_addr;
      DataIn    <= src_wdata;
    end
  end

  // read data captured the cycle MOC is seen during a read
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= '0;
    else if (state == WAIT_MOC && MOC && lat_rw == RW_READ)
      rdata <= ext_data;
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator: directed + random accesses against a
// byte-array RAM model and a big-endian reference memory.
module tb_mem_access_initiator;
  import mem_if_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, done, err, MOV, ReadWrite, MOCoff;
  logic [31:0] rdata, Address, DataIn;
  logic [2:0]  MS_2_0;
  logic        MOC = 1'b0;
  logic [31:0] DataOut = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_initiator #(
    .TIMEOUT_CYCLES (TMO),
    .CHECK_ALIGN    (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .MOV        (MOV),
    .ReadWrite  (ReadWrite),
    .MS_2_0     (MS_2_0),
    .Address    (Address),
    .DataIn     (DataIn),
    .MOCoff     (MOCoff),
    .MOC        (MOC),
    .DataOut    (DataOut)
  );

  // RAM model: MOC rises the cycle MOV is seen, falls after
  // clr_delay further MOCoff cycles; dead=1 never answers
  logic [7:0] ram [0:255] = '{default: 8'h00};
  bit         dead = 1'b0;
  int         clr_delay = 0;
  int         stale_token = 0;
  int         stale_seen = 0;
  int         clr_cnt = 0;
  logic [7:0]  ra;
  logic [31:0] rr;

  always @(posedge clk) begin
    #1;
    ra = Address[7:0];
    rr = $urandom();
    if (stale_token != stale_seen) begin
      stale_seen = stale_token;
      MOC = 1'b1;
      clr_cnt = 0;
    end else if (MOV && !MOC && !dead) begin
      if (ReadWrite) begin
        case (MS_2_0[1:0])
          2'b00: DataOut = {rr[31:8], ram[ra]};
          2'b01: DataOut = {rr[31:16], ram[ra], ram[ra+8'd1]};
          default: DataOut = {ram[ra], ram[ra+8'd1],
                              ram[ra+8'd2], ram[ra+8'd3]};
        endcase
      end else begin
        case (MS_2_0[1:0])
          2'b00: ram[ra] = DataIn[7:0];
          2'b01: begin
            ram[ra]      = DataIn[15:8];
            ram[ra+8'd1] = DataIn[7:0];
          end
          default: begin
            ram[ra]      = DataIn[31:24];
            ram[ra+8'd1] = DataIn[23:16];
            ram[ra+8'd2] = DataIn[15:8];
            ram[ra+8'd3] = DataIn[7:0];
          end
        endcase
      end
      MOC = 1'b1;
      clr_cnt = 0;
    end else if (MOCoff && MOC) begin
      if (clr_cnt >= clr_delay) MOC = 1'b0;
      else clr_cnt++;
    end
  end

  // reference memory, updated only from completed stores
  bit [7:0] ref_mem [0:255];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
  endfunction

  task automatic ref_write(input logic [1:0] sz,
                           input logic [31:0] a,
                           input logic [31:0] wd);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++)
      ref_mem[8'(a + i)] = 8'((wd >> (8 * (n - 1 - i))) & 255);
  endtask

  function automatic logic [31:0] ref_read(input logic [1:0] sz,
                                           input logic sg,
                                           input logic [31:0] a);
    int n = nbytes(sz);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v = v * 256 + ref_mem[8'(a + i)];
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          done_at, err_at, movs, mocoffs;
  logic        busy_after, pulse_after, mocoff_after;
  logic        mocoff_at_err;
  logic [31:0] o_addr, o_din;
  logic        o_rw;
  logic [2:0]  o_ms;

  task automatic run(input logic rw, input logic [1:0] sz,
                     input logic sg, input logic [31:0] ad,
                     input logic [31:0] wd, input int limit);
    int k = 0;
    done_at = 0; err_at = 0; movs = 0; mocoffs = 0;
    mocoff_at_err = 1'b0;
    @(negedge clk);
    req = 1'b1; req_rw = rw; req_size = sz;
    req_signed = sg; req_addr = ad; req_wdata = wd;
    do begin
      @(negedge clk);
      req = 1'b0;
      k++;
      if (MOV) begin
        movs++;
        o_addr = Address; o_din = DataIn;
        o_rw = ReadWrite; o_ms = MS_2_0;
      end
      if (MOCoff) mocoffs++;
      if (done && done_at == 0) done_at = k;
      if (err && err_at == 0) begin
        err_at = k;
        mocoff_at_err = MOCoff;
      end
    end while (done_at == 0 && err_at == 0 && k < limit);
    @(negedge clk);
    busy_after = busy;
    pulse_after = done | err;
    mocoff_after = MOCoff;
  endtask

  task automatic ok_access(input string tag, input logic rw,
                           input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad,
                           input logic [31:0] wd);
    run(rw, sz, sg, ad, wd, 20);
    check({tag, "_done_at"}, done_at, 3);
    check({tag, "_err"}, err_at, 0);
    check({tag, "_movs"}, movs, 1);
    check({tag, "_busy_after"}, busy_after, 1'b0);
    if (rw == RW_READ)
      check({tag, "_rdata"}, rdata, ref_read(sz, sg, ad));
    else
      ref_write(sz, ad, wd);
  endtask

  task automatic err_case(input string tag, input logic [1:0] sz,
                          input logic [31:0] ad);
    run(RW_READ, sz, 1'b0, ad, 32'h0, 10);
    check({tag, "_err_at"}, err_at, 1);
    check({tag, "_movs"}, movs, 0);
    check({tag, "_done"}, done_at, 0);
    check({tag, "_busy_after"}, busy_after, 1'b0);
    check({tag, "_pulse_after"}, pulse_after, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ctl"},
          {24'h0, MOV, MOCoff, busy, done, err, ReadWrite, MS_2_0[1:0]},
          32'h0);
    check({tag, "_ms2"}, MS_2_0[2], 1'b0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_addr"}, Address, 32'h0);
    check({tag, "_din"}, DataIn, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic        rw, sg;
    logic [1:0]  sz;
    logic [31:0] ad, wd, mask;
    int          quiet;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    ok_access("wr_w10", RW_WRITE, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    check("wr_w10_addr", o_addr, 32'h10);
    check("wr_w10_din", o_din, 32'hDEADBEEF);
    check("wr_w10_rw", o_rw, 1'b0);
    check("wr_w10_ms", o_ms, 3'b010);
    ok_access("rd_w10", RW_READ, SZ_WORD, 1'b0, 32'h10, 32'h0);
    check("rd_w10_const", rdata, 32'hDEADBEEF);
    check("rd_w10_rw", o_rw, 1'b1);

    ok_access("wr_b21", RW_WRITE, SZ_BYTE, 1'b0, 32'h21, 32'h12345685);
    ok_access("rd_b21s", RW_READ, SZ_BYTE, 1'b1, 32'h21, 32'h0);
    check("rd_b21s_const", rdata, 32'hFFFFFF85);
    check("rd_b21s_ms", o_ms, 3'b100);
    ok_access("rd_b21u", RW_READ, SZ_BYTE, 1'b0, 32'h21, 32'h0);
    check("rd_b21u_const", rdata, 32'h00000085);

    ok_access("wr_h30", RW_WRITE, SZ_HALF, 1'b0, 32'h30, 32'hABCD8001);
    ok_access("rd_h30s", RW_READ, SZ_HALF, 1'b1, 32'h30, 32'h0);
    check("rd_h30s_const", rdata, 32'hFFFF8001);
    ok_access("rd_h30u", RW_READ, SZ_HALF, 1'b0, 32'h30, 32'h0);
    check("rd_h30u_const", rdata, 32'h00008001);

    err_case("mis_w13", SZ_WORD, 32'h13);
    err_case("mis_w12", SZ_WORD, 32'h12);
    err_case("mis_h31", SZ_HALF, 32'h31);
    err_case("bad_size", SZ_BAD, 32'h20);
    check("err_keeps_rdata", rdata, 32'h00008001);

    dead = 1'b1;
    run(RW_READ, SZ_WORD, 1'b0, 32'h10, 32'h0, 40);
    check("tmo_movs", movs, TMO);
    check("tmo_err_at", err_at, TMO + 1);
    check("tmo_done", done_at, 0);
    check("tmo_mocoff", mocoff_at_err, 1'b1);
    check("tmo_mocoff_drop", mocoff_after, 1'b0);
    check("tmo_busy_after", busy_after, 1'b0);
    dead = 1'b0;
    ok_access("after_tmo", RW_READ, SZ_WORD, 1'b0, 32'h10, 32'h0);

    clr_delay = 2;
    stale_token++;
    run(RW_READ, SZ_BYTE, 1'b0, 32'h21, 32'h0, 40);
    check("stale_done_at", done_at, 8);
    check("stale_movs", movs, 1);
    check("stale_mocoffs", mocoffs, 6);
    check("stale_err", err_at, 0);
    check("stale_rdata", rdata, 32'h00000085);
    clr_delay = 0;

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      mask = (sz == SZ_WORD) ? 32'hFC :
             (sz == SZ_HALF) ? 32'hFE : 32'hFF;
      ad = 32'($urandom_range(0, 255)) & mask;
      wd = $urandom();
      ok_access("rnd", rw, sz, sg, ad, wd);
    end

    dead = 1'b1;
    @(negedge clk);
    req = 1'b1; req_rw = RW_READ; req_size = SZ_WORD;
    req_signed = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req = 1'b0;
    check("mid_mov", MOV, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    reset = 1'b0;
    dead = 1'b0;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || err || busy || MOV) quiet++;
    end
    check("mid_reset_quiet", quiet, 0);
    ok_access("after_rst", RW_READ, SZ_WORD, 1'b0, 32'h10, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
